// File: rtl/mem_controller_rr.sv
// Multi-channel memory controller: round-robin grant of consumer requests to free channels,
// valid/ready forwarding to memory, optional per-channel timeout and read-only write refusal.
module mem_controller_rr #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int NUM_CHANNELS   = 2,
  parameter bit WRITE_ENABLE   = 1'b1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           i_consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] i_consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           o_consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] o_consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           i_consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] i_consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] i_consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           o_consumer_write_ready,
  output logic [NUM_CONSUMERS-1:0]           o_consumer_error,
  output logic [NUM_CHANNELS-1:0]            o_mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  o_mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            i_mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  i_mem_read_data,
  output logic [NUM_CHANNELS-1:0]            o_mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  o_mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  o_mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            i_mem_write_ready,
  output logic [NUM_CHANNELS-1:0]            o_channel_busy
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LOAD    = TW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_CONSUMER = CW'(NUM_CONSUMERS - 1);

  // IDLE: free | READ_WAIT/WRITE_WAIT: memory handshake | RELAY: holding response to consumer
  typedef enum logic [1:0] {S_IDLE, S_READ_WAIT, S_WRITE_WAIT, S_RELAY} state_t;

  state_t                             r_state [NUM_CHANNELS];
  logic [CW-1:0]                      r_owner [NUM_CHANNELS];
  logic [TW-1:0]                      r_timer [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]            r_is_write;
  logic [CW-1:0]                      r_rr_ptr;
  logic [NUM_CONSUMERS-1:0]           r_read_ready, r_write_ready, r_error;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] r_read_data;
  logic [NUM_CHANNELS-1:0]            r_mem_read_valid, r_mem_write_valid, r_busy;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  r_mem_read_address, r_mem_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  r_mem_write_data;

  logic [NUM_CONSUMERS-1:0] w_request, w_claimed, w_taken;
  logic [NUM_CHANNELS-1:0]  w_grant;
  logic [CW-1:0]            w_grant_idx [NUM_CHANNELS];
  logic [CW-1:0]            w_scan;
  logic [CW-1:0]            w_rr_next;

  assign w_request = i_consumer_read_valid | i_consumer_write_valid;

  always_comb begin
    w_claimed = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++)
      if (r_state[ch] != S_IDLE) w_claimed[r_owner[ch]] = 1'b1;
  end

  // Later channels see earlier channels' picks through w_taken, so one cycle never double-grants.
  always_comb begin
    w_taken   = w_claimed;
    w_grant   = '0;
    w_scan    = '0;
    w_rr_next = r_rr_ptr;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_grant_idx[ch] = '0;
      if (r_state[ch] == S_IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          w_scan = CW'((int'(r_rr_ptr) + k) % NUM_CONSUMERS);
          if (!w_grant[ch] && w_request[w_scan] && !w_taken[w_scan]) begin
            w_grant[ch]     = 1'b1;
            w_grant_idx[ch] = w_scan;
          end
        end
      end
      if (w_grant[ch]) begin
        w_taken[w_grant_idx[ch]] = 1'b1;
        w_rr_next = (w_grant_idx[ch] == LAST_CONSUMER) ? '0 : w_grant_idx[ch] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr            <= '0;
      r_is_write          <= '0;
      r_read_ready        <= '0;
      r_write_ready       <= '0;
      r_error             <= '0;
      r_read_data         <= '0;
      r_mem_read_valid    <= '0;
      r_mem_read_address  <= '0;
      r_mem_write_valid   <= '0;
      r_mem_write_address <= '0;
      r_mem_write_data    <= '0;
      r_busy              <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_state[ch] <= S_IDLE;
        r_owner[ch] <= '0;
        r_timer[ch] <= '0;
      end
    end else begin
      r_rr_ptr <= w_rr_next;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (r_state[ch])
          S_IDLE: begin
            if (w_grant[ch]) begin
              r_owner[ch] <= w_grant_idx[ch];
              r_timer[ch] <= TIMER_LOAD;
              r_busy[ch]  <= 1'b1;
              if (i_consumer_read_valid[w_grant_idx[ch]]) begin
                r_is_write[ch]       <= 1'b0;
                r_mem_read_valid[ch] <= 1'b1;
                r_mem_read_address[ch*ADDR_BITS +: ADDR_BITS] <=
                  i_consumer_read_address[w_grant_idx[ch]*ADDR_BITS +: ADDR_BITS];
                r_state[ch] <= S_READ_WAIT;
              end else if (WRITE_ENABLE) begin
                r_is_write[ch]        <= 1'b1;
                r_mem_write_valid[ch] <= 1'b1;
                r_mem_write_address[ch*ADDR_BITS +: ADDR_BITS] <=
                  i_consumer_write_address[w_grant_idx[ch]*ADDR_BITS +: ADDR_BITS];
                r_mem_write_data[ch*DATA_BITS +: DATA_BITS] <=
                  i_consumer_write_data[w_grant_idx[ch]*DATA_BITS +: DATA_BITS];
                r_state[ch] <= S_WRITE_WAIT;
              end else begin
                r_is_write[ch]                 <= 1'b1;
                r_write_ready[w_grant_idx[ch]] <= 1'b1;
                r_error[w_grant_idx[ch]]       <= 1'b1;
                r_state[ch]                    <= S_RELAY;
              end
            end
          end
          S_READ_WAIT: begin
            if (i_mem_read_ready[ch]) begin
              r_mem_read_valid[ch]  <= 1'b0;
              r_read_data[r_owner[ch]*DATA_BITS +: DATA_BITS] <=
                i_mem_read_data[ch*DATA_BITS +: DATA_BITS];
              r_read_ready[r_owner[ch]] <= 1'b1;
              r_error[r_owner[ch]]      <= 1'b0;
              r_state[ch]               <= S_RELAY;
            end else if ((TIMEOUT_CYCLES > 0) && (r_timer[ch] == TW'(1))) begin
              r_mem_read_valid[ch] <= 1'b0;
              r_read_data[r_owner[ch]*DATA_BITS +: DATA_BITS] <= '0;
              r_read_ready[r_owner[ch]] <= 1'b1;
              r_error[r_owner[ch]]      <= 1'b1;
              r_state[ch]               <= S_RELAY;
            end else begin
              r_timer[ch] <= r_timer[ch] - TW'(1);
            end
          end
          S_WRITE_WAIT: begin
            if (i_mem_write_ready[ch]) begin
              r_mem_write_valid[ch]      <= 1'b0;
              r_write_ready[r_owner[ch]] <= 1'b1;
              r_error[r_owner[ch]]       <= 1'b0;
              r_state[ch]                <= S_RELAY;
            end else if ((TIMEOUT_CYCLES > 0) && (r_timer[ch] == TW'(1))) begin
              r_mem_write_valid[ch]      <= 1'b0;
              r_write_ready[r_owner[ch]] <= 1'b1;
              r_error[r_owner[ch]]       <= 1'b1;
              r_state[ch]                <= S_RELAY;
            end else begin
              r_timer[ch] <= r_timer[ch] - TW'(1);
            end
          end
          S_RELAY: begin
            if (r_is_write[ch] ? !i_consumer_write_valid[r_owner[ch]]
                               : !i_consumer_read_valid[r_owner[ch]]) begin
              r_read_ready[r_owner[ch]]  <= 1'b0;
              r_write_ready[r_owner[ch]] <= 1'b0;
              r_error[r_owner[ch]]       <= 1'b0;
              r_busy[ch]                 <= 1'b0;
              r_state[ch]                <= S_IDLE;
            end
          end
          default: r_state[ch] <= S_IDLE;
        endcase
      end
    end
  end

  assign o_consumer_read_ready  = r_read_ready;
  assign o_consumer_read_data   = r_read_data;
  assign o_consumer_write_ready = r_write_ready;
  assign o_consumer_error       = r_error;
  assign o_mem_read_valid       = r_mem_read_valid;
  assign o_mem_read_address     = r_mem_read_address;
  assign o_mem_write_valid      = r_mem_write_valid;
  assign o_mem_write_address    = r_mem_write_address;
  assign o_mem_write_data       = r_mem_write_data;
  assign o_channel_busy         = r_busy;

endmodule

// File: tb/tb_mem_controller_rr.sv
// Bench for mem_controller_rr: instance A (1 channel, writes enabled, no timeout) and
// instance B (2 channels, read-only, timeout 5), checked against a consumer-level model.
module tb_mem_controller_rr;
  localparam int AB = 8;
  localparam int DB = 16;
  localparam int NC = 4;
  localparam int B_TO = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NC-1:0]    a_rv, a_rr, a_wv, a_wr, a_err;
  logic [NC*AB-1:0] a_raddr, a_waddr;
  logic [NC*DB-1:0] a_rdata, a_wdata;
  logic             a_mrv, a_mrr, a_mwv, a_mwr, a_busy;
  logic [AB-1:0]    a_mraddr, a_mwaddr;
  logic [DB-1:0]    a_mrdata, a_mwdata;

  logic [NC-1:0]    b_rv, b_rr, b_wv, b_wr, b_err;
  logic [NC*AB-1:0] b_raddr, b_waddr;
  logic [NC*DB-1:0] b_rdata, b_wdata;
  logic [1:0]       b_mrv, b_mrr, b_mwv, b_mwr, b_busy;
  logic [2*AB-1:0]  b_mraddr, b_mwaddr;
  logic [2*DB-1:0]  b_mrdata, b_mwdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [DB-1:0] ext_mem   [256];
  logic [DB-1:0] model_mem [256];

  mem_controller_rr #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1),
                      .WRITE_ENABLE(1'b1), .TIMEOUT_CYCLES(0)) u_dut_a (
    .clk(clk), .reset(reset),
    .i_consumer_read_valid(a_rv), .i_consumer_read_address(a_raddr),
    .o_consumer_read_ready(a_rr), .o_consumer_read_data(a_rdata),
    .i_consumer_write_valid(a_wv), .i_consumer_write_address(a_waddr),
    .i_consumer_write_data(a_wdata), .o_consumer_write_ready(a_wr), .o_consumer_error(a_err),
    .o_mem_read_valid(a_mrv), .o_mem_read_address(a_mraddr),
    .i_mem_read_ready(a_mrr), .i_mem_read_data(a_mrdata),
    .o_mem_write_valid(a_mwv), .o_mem_write_address(a_mwaddr), .o_mem_write_data(a_mwdata),
    .i_mem_write_ready(a_mwr), .o_channel_busy(a_busy));

  mem_controller_rr #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(2),
                      .WRITE_ENABLE(1'b0), .TIMEOUT_CYCLES(B_TO)) u_dut_b (
    .clk(clk), .reset(reset),
    .i_consumer_read_valid(b_rv), .i_consumer_read_address(b_raddr),
    .o_consumer_read_ready(b_rr), .o_consumer_read_data(b_rdata),
    .i_consumer_write_valid(b_wv), .i_consumer_write_address(b_waddr),
    .i_consumer_write_data(b_wdata), .o_consumer_write_ready(b_wr), .o_consumer_error(b_err),
    .o_mem_read_valid(b_mrv), .o_mem_read_address(b_mraddr),
    .i_mem_read_ready(b_mrr), .i_mem_read_data(b_mrdata),
    .o_mem_write_valid(b_mwv), .o_mem_write_address(b_mwaddr), .o_mem_write_data(b_mwdata),
    .i_mem_write_ready(b_mwr), .o_channel_busy(b_busy));

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 600000", $time);
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1;
    a_rv = '0; a_wv = '0; a_raddr = '0; a_waddr = '0; a_wdata = '0;
    a_mrr = 1'b0; a_mwr = 1'b0; a_mrdata = '0;
    b_rv = '0; b_wv = '0; b_raddr = '0; b_waddr = '0; b_wdata = '0;
    b_mrr = '0; b_mwr = '0; b_mrdata = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_rr, a_wr, a_err, a_rdata} !== '0) begin
      n_errors++; $display("FAIL reset_a_consumer: got %0h expected 0", {a_rr, a_wr, a_err, a_rdata});
    end
    n_checks++;
    if ({a_mrv, a_mraddr, a_mwv, a_mwaddr, a_mwdata, a_busy} !== '0) begin
      n_errors++; $display("FAIL reset_a_mem: got %0h expected 0", {a_mrv, a_mraddr, a_mwv, a_mwaddr, a_mwdata, a_busy});
    end
    n_checks++;
    if ({b_rr, b_wr, b_err, b_rdata, b_mrv, b_mraddr, b_mwv, b_mwaddr, b_mwdata, b_busy} !== '0) begin
      n_errors++; $display("FAIL reset_b: got %0h expected 0", {b_rr, b_wr, b_err, b_rdata, b_busy});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    a_raddr[2*AB +: AB] = 8'h3C;
    a_rv[2] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_mrv !== 1'b1 || a_mraddr !== 8'h3C) begin
      n_errors++; $display("FAIL single_mem_req: got valid %b addr %0h expected 1 3c", a_mrv, a_mraddr);
    end
    @(negedge clk);
    n_checks++;
    if (a_rr[2] !== 1'b0) begin
      n_errors++; $display("FAIL single_early_ready: got %b expected 0", a_rr[2]);
    end
    @(negedge clk);
    a_mrr = 1'b1; a_mrdata = 16'hBEEF;
    @(negedge clk);
    a_mrr = 1'b0;
    n_checks++;
    if (a_rr !== 4'b0100 || a_rdata[2*DB +: DB] !== 16'hBEEF || a_err[2] !== 1'b0 || a_mrv !== 1'b0) begin
      n_errors++; $display("FAIL single_resp: got rdy %b data %0h err %b mv %b expected 0100 beef 0 0",
                           a_rr, a_rdata[2*DB +: DB], a_err[2], a_mrv);
    end
    @(negedge clk);
    n_checks++;
    if (a_rr[2] !== 1'b1) begin
      n_errors++; $display("FAIL single_hold: got %b expected 1", a_rr[2]);
    end
    a_rv[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_rr[2] !== 1'b0 || a_busy !== 1'b0) begin
      n_errors++; $display("FAIL single_release: got rdy %b busy %b expected 0 0", a_rr[2], a_busy);
    end
  endtask

  task automatic test_fairness();
    int exp_next = 3;
    int grants = 0;
    int g;
    for (int i = 0; i < NC; i++) a_raddr[i*AB +: AB] = AB'(i << 6);
    a_rv = '1;
    for (int cyc = 0; cyc < 300 && grants < 12; cyc++) begin
      @(negedge clk);
      if (a_mrr) a_mrr = 1'b0;
      else if (a_mrv) begin
        g = int'(a_mraddr[7:6]);
        n_checks++;
        if (g !== exp_next) begin
          n_errors++; $display("FAIL fair_order: got consumer %0d expected %0d", g, exp_next);
        end
        exp_next = (g + 1) % NC;
        grants++;
        a_mrr = 1'b1; a_mrdata = 16'hF000 | DB'(g);
      end
      for (int i = 0; i < NC; i++) begin
        if (a_rv[i] && a_rr[i]) begin
          n_checks++;
          if (a_rdata[i*DB +: DB] !== (16'hF000 | DB'(i))) begin
            n_errors++; $display("FAIL fair_data: got %0h expected %0h", a_rdata[i*DB +: DB], 16'hF000 | DB'(i));
          end
          a_rv[i] = 1'b0;
        end else if (!a_rv[i] && !a_rr[i]) a_rv[i] = 1'b1;
      end
    end
    n_checks++;
    if (grants != 12) begin
      n_errors++; $display("FAIL fair_progress: got %0d grants expected 12", grants);
    end
  endtask

  task automatic drain_a();
    a_rv = '0; a_wv = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (a_mrr) a_mrr = 1'b0; else if (a_mrv) a_mrr = 1'b1;
      if (a_mwr) a_mwr = 1'b0; else if (a_mwv) a_mwr = 1'b1;
      if (!a_busy && !a_mrr && !a_mwr && !a_mrv && !a_mwv) break;
    end
    n_checks++;
    if (a_busy !== 1'b0) begin
      n_errors++; $display("FAIL drain_a: got busy %b expected 0", a_busy);
    end
  endtask

  task automatic test_reset_mid();
    a_raddr[2*AB +: AB] = 8'h77;
    a_rv[2] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_mrv !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_wait: got %b expected 1", a_mrv);
    end
    reset = 1'b1; a_rv = '0;
    @(negedge clk);
    n_checks++;
    if ({a_mrv, a_mraddr, a_busy, a_rr, a_err} !== '0) begin
      n_errors++; $display("FAIL rstmid_clear: got %0h expected 0", {a_mrv, a_mraddr, a_busy, a_rr, a_err});
    end
    reset = 1'b0;
    a_raddr[1*AB +: AB] = 8'h41; a_raddr[3*AB +: AB] = 8'hC3;
    a_rv = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (a_mrv !== 1'b1 || a_mraddr !== 8'h41) begin
      n_errors++; $display("FAIL rstmid_ptr: got valid %b addr %0h expected 1 41", a_mrv, a_mraddr);
    end
    a_mrr = 1'b1; a_mrdata = 16'h4141;
    @(negedge clk);
    a_mrr = 1'b0;
    n_checks++;
    if (a_rr !== 4'b0010 || a_rdata[1*DB +: DB] !== 16'h4141) begin
      n_errors++; $display("FAIL rstmid_resp: got rdy %b data %0h expected 0010 4141", a_rr, a_rdata[1*DB +: DB]);
    end
  endtask

  task automatic test_random_traffic();
    int pend [NC];
    logic [AB-1:0] paddr [NC];
    logic [DB-1:0] pdata [NC];
    int done = 0;
    logic [AB-1:0] ad;
    for (int a = 0; a < 256; a++) begin
      model_mem[a] = {AB'(a), ~AB'(a)};
      ext_mem[a]   = {AB'(a), ~AB'(a)};
    end
    for (int i = 0; i < NC; i++) pend[i] = 0;
    a_rv = '0; a_wv = '0; a_mrr = 1'b0; a_mwr = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (a_mrr) a_mrr = 1'b0;
      else if (a_mrv && $urandom_range(2) == 0) begin a_mrr = 1'b1; a_mrdata = ext_mem[a_mraddr]; end
      if (a_mwr) a_mwr = 1'b0;
      else if (a_mwv && $urandom_range(2) == 0) begin a_mwr = 1'b1; ext_mem[a_mwaddr] = a_mwdata; end
      for (int i = 0; i < NC; i++) begin
        if (pend[i] == 1 && a_rr[i]) begin
          n_checks++;
          if (a_rdata[i*DB +: DB] !== model_mem[paddr[i]] || a_err[i] !== 1'b0) begin
            n_errors++; $display("FAIL rand_read c%0d: got %0h err %b expected %0h err 0",
                                 i, a_rdata[i*DB +: DB], a_err[i], model_mem[paddr[i]]);
          end
          a_rv[i] = 1'b0; pend[i] = 0; done++;
        end else if (pend[i] == 2 && a_wr[i]) begin
          n_checks++;
          if (a_err[i] !== 1'b0) begin
            n_errors++; $display("FAIL rand_write c%0d: got err %b expected 0", i, a_err[i]);
          end
          model_mem[paddr[i]] = pdata[i];
          a_wv[i] = 1'b0; pend[i] = 0; done++;
        end else if (pend[i] == 0) begin
          n_checks++;
          if (a_rr[i] !== 1'b0 || a_wr[i] !== 1'b0) begin
            n_errors++; $display("FAIL rand_spurious c%0d: got rdy %b wrdy %b expected 0 0", i, a_rr[i], a_wr[i]);
          end
          if (cyc < 850 && $urandom_range(1) == 0) begin
            ad = {2'(i), 6'($urandom_range(63))};
            paddr[i] = ad;
            if ($urandom_range(1) == 0) begin
              a_raddr[i*AB +: AB] = ad; a_rv[i] = 1'b1; pend[i] = 1;
            end else begin
              pdata[i] = DB'($urandom);
              a_waddr[i*AB +: AB] = ad; a_wdata[i*DB +: DB] = pdata[i]; a_wv[i] = 1'b1; pend[i] = 2;
            end
          end
        end
      end
    end
    for (int i = 0; i < NC; i++) begin
      n_checks++;
      if (pend[i] != 0) begin
        n_errors++; $display("FAIL rand_stall c%0d: got pending %0d expected 0", i, pend[i]);
      end
    end
    n_checks++;
    if (done < 100) begin
      n_errors++; $display("FAIL rand_throughput: got %0d completions expected >= 100", done);
    end
  endtask

  task automatic test_parallel();
    b_raddr[1*AB +: AB] = 8'h21; b_raddr[3*AB +: AB] = 8'h63;
    b_rv = 4'b1010;
    @(negedge clk);
    n_checks++;
    if (b_mrv !== 2'b11 || b_mraddr !== {8'h63, 8'h21}) begin
      n_errors++; $display("FAIL par_grant: got valid %b addr %0h expected 11 6321", b_mrv, b_mraddr);
    end
    b_mrr = 2'b11; b_mrdata = {16'h3333, 16'h1111};
    @(negedge clk);
    b_mrr = 2'b00;
    n_checks++;
    if (b_rr !== 4'b1010 || b_rdata[1*DB +: DB] !== 16'h1111 || b_rdata[3*DB +: DB] !== 16'h3333 || b_err !== '0) begin
      n_errors++; $display("FAIL par_resp: got rdy %b d1 %0h d3 %0h err %b expected 1010 1111 3333 0000",
                           b_rr, b_rdata[1*DB +: DB], b_rdata[3*DB +: DB], b_err);
    end
    b_rv = '0;
    @(negedge clk);
    n_checks++;
    if (b_rr !== '0 || b_busy !== 2'b00) begin
      n_errors++; $display("FAIL par_release: got rdy %b busy %b expected 0000 00", b_rr, b_busy);
    end
  endtask

  task automatic test_timeout();
    b_raddr[1*AB +: AB] = 8'h55;
    b_rv[1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (b_mrv !== 2'b01) begin
      n_errors++; $display("FAIL tmo_grant: got %b expected 01", b_mrv);
    end
    for (int cyc = 1; cyc <= B_TO; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (cyc < B_TO && b_rr[1] !== 1'b0) begin
        n_errors++; $display("FAIL tmo_early: got ready %b at wait %0d expected 0", b_rr[1], cyc);
      end else if (cyc == B_TO && (b_rr[1] !== 1'b1 || b_err[1] !== 1'b1 ||
                                   b_rdata[1*DB +: DB] !== '0 || b_mrv !== 2'b00)) begin
        n_errors++; $display("FAIL tmo_resp: got rdy %b err %b data %0h mv %b expected 1 1 0 00",
                             b_rr[1], b_err[1], b_rdata[1*DB +: DB], b_mrv);
      end
    end
    b_rv[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_rr[1] !== 1'b0 || b_err[1] !== 1'b0 || b_busy !== 2'b00) begin
      n_errors++; $display("FAIL tmo_release: got rdy %b err %b busy %b expected 0 0 00", b_rr[1], b_err[1], b_busy);
    end
  endtask

  task automatic test_ready_beats_timeout();
    b_raddr[0 +: AB] = 8'h22;
    b_rv[0] = 1'b1;
    repeat (B_TO) @(negedge clk);
    b_mrr = 2'b01; b_mrdata = {16'h0000, 16'hA5A5};
    @(negedge clk);
    b_mrr = 2'b00;
    n_checks++;
    if (b_rr[0] !== 1'b1 || b_err[0] !== 1'b0 || b_rdata[0 +: DB] !== 16'hA5A5) begin
      n_errors++; $display("FAIL race_resp: got rdy %b err %b data %0h expected 1 0 a5a5", b_rr[0], b_err[0], b_rdata[0 +: DB]);
    end
    b_rv[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_refused();
    b_waddr[2*AB +: AB] = 8'h10; b_wdata[2*DB +: DB] = 16'h1234;
    b_wv[2] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (b_wr !== 4'b0100 || b_err !== 4'b0100 || b_mwv !== 2'b00 || b_busy === 2'b00) begin
      n_errors++; $display("FAIL ro_resp: got wrdy %b err %b mwv %b busy %b expected 0100 0100 00 nonzero",
                           b_wr, b_err, b_mwv, b_busy);
    end
    @(negedge clk);
    n_checks++;
    if (b_wr[2] !== 1'b1 || b_mwv !== 2'b00) begin
      n_errors++; $display("FAIL ro_hold: got wrdy %b mwv %b expected 1 00", b_wr[2], b_mwv);
    end
    b_wv[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_wr !== '0 || b_err !== '0 || b_busy !== 2'b00 || b_mwv !== 2'b00) begin
      n_errors++; $display("FAIL ro_release: got wrdy %b err %b busy %b mwv %b expected 0", b_wr, b_err, b_busy, b_mwv);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    drain_a();
    test_reset_mid();
    drain_a();
    test_random_traffic();
    test_parallel();
    test_timeout();
    test_ready_beats_timeout();
    test_write_refused();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
